my_mult16_seq: RTL and testbench

MY_MULT16_SEQ -- requirements
Module: my_mult16_seq

---
 rtl/my_arith_pkg.sv | 6 +
 rtl/my_add16c.sv | 17 +
 rtl/my_mult16_seq.sv | 65 ++++++
 tb/tb_my_mult16_seq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/my_arith_pkg.sv
// my_arith_pkg: shared width/step constants and multiplier FSM state type.
package my_arith_pkg;
   localparam int WIDTH = 16;
   localparam int STEPS = 16;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/my_add16c.sv
// my_add16c: combinational 16-bit ripple-carry adder of full-adder cells with carry out.
module my_add16c
   import my_arith_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);
   logic [WIDTH:0] w_c;
   assign w_c[0] = 1'b0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end
   assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/my_mult16_seq.sv
// my_mult16_seq: 16x16 unsigned shift-add multiplier, one step per cycle.
// Optional MY_MULT16_ZERO_SKIP_EN short-circuits zero operands straight to DONE.
module my_mult16_seq
   import my_arith_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_mcand, r_hi, r_lo, w_addend, w_sum;
   logic [4:0]       r_cnt;
   logic             w_cout, w_zero, w_accept;

`ifdef MY_MULT16_ZERO_SKIP_EN
   assign w_zero = (a == '0) || (b == '0);
`else
   assign w_zero = 1'b0;
`endif

   assign w_accept = (r_state == IDLE) && start;
   assign w_addend = r_lo[0] ? r_mcand : '0;

   my_add16c u_add (.i_a(r_hi), .i_b(w_addend), .o_sum(w_sum), .o_cout(w_cout));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = start ? (w_zero ? DONE : RUN) : IDLE;
         RUN:     w_next = (r_cnt == 5'(STEPS - 1)) ? DONE : RUN;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= w_zero ? '0 : b;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            {r_hi, r_lo} <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
            r_cnt        <= r_cnt + 5'd1;
         end
      end
   end

   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE);
   assign product = {r_hi, r_lo};
endmodule

// File: tb/tb_my_mult16_seq.sv
// tb_my_mult16_seq: scoreboard bench, expected a*b queued at issue, checked on each done.
module tb_my_mult16_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] product;
   logic [31:0] exp_q[$];
   int          total = 0, bad = 0;

   my_mult16_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && done) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: product=%h with nothing outstanding", product);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (product !== e) begin
               bad++;
               $display("FAIL product: got=%h expected=%h", product, e);
            end
         end
      end
   end

   function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y);
`ifdef MY_MULT16_ZERO_SKIP_EN
      return (x == 0 || y == 0) ? 1 : 17;
`else
      return 17;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, want);
      end
   endtask

   task automatic do_op(input logic [15:0] x, input logic [15:0] y);
      int n;
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      exp_q.push_back(32'(x) * 32'(y));
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'(exp_lat(x, y)));
      @(negedge clk);
      check("product_hold", product, 32'(x) * 32'(y));
   endtask

   initial begin
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_product", product, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(16'd3, 16'd5);
      do_op(16'hFFFF, 16'hFFFF);
      do_op(16'd0, 16'hABCD);
      do_op(16'hABCD, 16'd0);
      do_op(16'd1, 16'hFFFF);

      @(negedge clk);
      a = 16'h1234; b = 16'h0002; start = 1'b1;
      exp_q.push_back(32'h0000_2468);
      repeat (18) @(negedge clk);
      check("held_start_idle", {31'd0, busy}, 32'd0);
      start = 1'b0;
      repeat (25) @(negedge clk);
      check("held_start_single", 32'(exp_q.size()), 32'd0);
      do_op(16'h1234, 16'h0002);

      @(negedge clk);
      a = 16'd7; b = 16'd9; start = 1'b1;
      exp_q.push_back(32'd63);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_product", product, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'd7, 16'd9);

      for (int i = 0; i < 1000; i++) begin
         logic [15:0] x, y;
         x = 16'($urandom);
         y = 16'($urandom);
         if (i % 50 == 0) x = 16'hFFFF;
         if (i % 70 == 0) y = 16'h0000;
         do_op(x, y);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
